// File: rtl/toll_coin_acceptor_pkg.sv
// Shared constants, state encoding and coin arithmetic for the toll coin acceptor.
package toll_coin_acceptor_pkg;

  localparam int unsigned CREDIT_W = 7;

  localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PAID    = 1'b1
  } state_e;

  // Cents contributed by the coin events seen in one cycle (max 40).
  function automatic logic [CREDIT_W-1:0] coin_sum(input logic nickel_ev,
                                                   input logic dime_ev,
                                                   input logic quarter_ev);
    logic [CREDIT_W-1:0] sum;
    sum = '0;
    if (nickel_ev)  sum = sum + NICKEL_C;
    if (dime_ev)    sum = sum + DIME_C;
    if (quarter_ev) sum = sum + QUARTER_C;
    return sum;
  endfunction

endpackage

// File: rtl/toll_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw input.
// Events are only armed once the synchronized level has been seen low after reset.
module toll_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic ev
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       ev_q, ev_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      ev_q    <= ev_d;
    end
  end

  // A level already high when reset releases never arms, so it cannot fire.
  always_comb begin
    s1_d    = d_raw;
    s2_d    = s1_q;
    s3_d    = s2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~s2_q);
    ev_d    = armed_q & s2_q & ~s3_q;
  end

  assign ev = ev_q;

endmodule

// File: rtl/toll_coin_acceptor.sv
// Toll booth coin acceptor: accumulates coins toward TOLL, returns change or
// refunds on cancel, and holds the paid lamp until the car leaves.
module toll_coin_acceptor
  import toll_coin_acceptor_pkg::*;
#(
  parameter int unsigned TOLL = 35
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Nickel,
  input  logic                Dime,
  input  logic                Quarter,
  input  logic                Cancel,
  input  logic                CarPassed,
  output logic                Paid,
  output logic [CREDIT_W-1:0] Credit,
  output logic [CREDIT_W-1:0] Change,
  output logic                ChangeValid
);

  localparam logic [CREDIT_W-1:0] TOLL_C = CREDIT_W'(TOLL);

  logic nickel_ev, dime_ev, quarter_ev, cancel_ev, car_ev;

  toll_sync_edge u_sync_nickel (
    .clk(Clk), .rst(Reset), .d_raw(Nickel), .ev(nickel_ev)
  );
  toll_sync_edge u_sync_dime (
    .clk(Clk), .rst(Reset), .d_raw(Dime), .ev(dime_ev)
  );
  toll_sync_edge u_sync_quarter (
    .clk(Clk), .rst(Reset), .d_raw(Quarter), .ev(quarter_ev)
  );
  toll_sync_edge u_sync_cancel (
    .clk(Clk), .rst(Reset), .d_raw(Cancel), .ev(cancel_ev)
  );
  toll_sync_edge u_sync_car (
    .clk(Clk), .rst(Reset), .d_raw(CarPassed), .ev(car_ev)
  );

  state_e              state_q, state_d;
  logic                paid_q, paid_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;

  logic [CREDIT_W-1:0] sum_c;
  logic [CREDIT_W-1:0] total_c;

  assign sum_c   = coin_sum(nickel_ev, dime_ev, quarter_ev);
  assign total_c = credit_q + sum_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_COLLECT;
      paid_q         <= 1'b0;
      credit_q       <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      paid_q         <= paid_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
    end
  end

  // Reaching the toll takes priority over a simultaneous cancel.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = '0;
    change_valid_d = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (total_c >= TOLL_C) begin
          state_d        = ST_PAID;
          credit_d       = '0;
          change_d       = total_c - TOLL_C;
          change_valid_d = 1'b1;
        end else if (cancel_ev) begin
          credit_d = '0;
          if (total_c != '0) begin
            change_d       = total_c;
            change_valid_d = 1'b1;
          end
        end else begin
          credit_d = total_c;
        end
      end
      ST_PAID: begin
        credit_d = '0;
        if (sum_c != '0) begin
          change_d       = sum_c;
          change_valid_d = 1'b1;
        end
        if (car_ev) begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d  = ST_COLLECT;
        credit_d = '0;
      end
    endcase

    paid_d = (state_d == ST_PAID);
  end

  assign Paid        = paid_q;
  assign Credit      = credit_q;
  assign Change      = change_q;
  assign ChangeValid = change_valid_q;

endmodule

// File: doc/toll_coin_acceptor.md
TOLL_COIN_ACCEPTOR -- requirements
Module: toll_coin_acceptor

Interface
REQ-001 Parameter: TOLL, default 35, toll price in cents; legal range 5..85, multiple of 5.
REQ-002 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Nickel  input  1  raw coin-sensor level; asynchronous; one high pulse of at least 1 Clk period per coin.
REQ-005 Dime  input  1  as Nickel, for 10 cents.
REQ-006 Quarter  input  1  as Nickel, for 25 cents.
REQ-007 Cancel  input  1  raw driver refund button; asynchronous level.
REQ-008 CarPassed  input  1  raw exit-loop sensor; asynchronous level.
REQ-009 Paid  output  1  high while the toll is satisfied; drives the booth go/stop lamp stage.
REQ-010 Credit  output  7  accumulated cents in the current transaction.
REQ-011 Change  output  7  refund amount in cents; valid only while ChangeValid is high.
REQ-012 ChangeValid  output  1  single-cycle strobe commanding the coin return.

Function
REQ-013 Each of the five raw inputs SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, yielding a 1-cycle event.
REQ-014 A level held high for multiple cycles SHALL produce exactly one event.
REQ-015 An input rising before Clk edge N SHALL affect registered outputs from edge N+3.
REQ-016 The FSM SHALL have two states: COLLECT (reset state) and PAID.
REQ-017 In COLLECT, the per-cycle coin sum SHALL be 5*nickel_ev + 10*dime_ev + 25*quarter_ev, so simultaneous coins all count (maximum 40).
REQ-018 In COLLECT, when Credit + sum < TOLL and no Cancel event occurs, Credit SHALL be updated to Credit + sum.
REQ-019 In COLLECT, when Credit + sum >= TOLL, the block SHALL go to PAID, set Paid=1, clear Credit to 0, and drive Change = Credit + sum - TOLL with ChangeValid=1 for one cycle.
REQ-020 The ChangeValid strobe SHALL occur even when Change is 0.
REQ-021 In COLLECT, a Cancel event with Credit + sum > 0 SHALL clear Credit and pulse ChangeValid with Change = Credit + sum.
REQ-022 A Cancel event with Credit + sum = 0 SHALL produce no strobe.
REQ-023 When Cancel and a toll-reaching coin arrive in the same cycle, the toll SHALL win (REQ-019) and Cancel SHALL be dropped.
REQ-024 In PAID, Paid SHALL stay 1, Credit SHALL stay 0, and Cancel SHALL be ignored.
REQ-025 In PAID, any coin event SHALL be refunded immediately: ChangeValid=1 and Change = sum in the same cycle.
REQ-026 A CarPassed event in PAID SHALL return the block to COLLECT with Paid=0 on the next edge.
REQ-027 A coin arriving in the same cycle as CarPassed in PAID SHALL still be refunded, not credited.
REQ-028 A CarPassed event in COLLECT SHALL be ignored.
REQ-029 Outside strobe cycles, Change SHALL hold 0.
REQ-030 All outputs SHALL be registered.
REQ-031 Credit arithmetic SHALL be 7-bit unsigned; the parameter range guarantees no overflow (maximum 80 + 40 = 120 < 128).

Reset
REQ-032 While Reset=1 at a Clk edge: state=COLLECT, Paid=0, Credit=0, Change=0, ChangeValid=0, and all synchronizer and edge-detect flops are cleared.
REQ-033 Reset mid-transaction SHALL discard credit without a refund strobe.
REQ-034 A coin level still high when Reset deasserts SHALL NOT generate an event.

Structure
REQ-035 A shared package/include file SHALL hold the coin value constants (NICKEL_C=5, DIME_C=10, QUARTER_C=25), the 2-value state encoding, and the credit width (7).
REQ-036 One sub-module, toll_sync_edge, SHALL implement the 2-flop synchronizer plus rising-edge detect, instantiated five times.

Verification
REQ-037 Reset, then Quarter then Dime pulses -> Credit 25 then 0; Paid=1; ChangeValid pulse with Change=0.
REQ-038 Dime, Dime, then Quarter -> Credit 10, 20; then Paid=1 with Change=10.
REQ-039 Nickel+Dime+Quarter in the same cycle from Credit 0 -> Paid=1, Change=5, one strobe.
REQ-040 Dime, Nickel, then Cancel -> Change=15 strobe, Credit=0, Paid stays 0; a second Cancel produces no strobe.
REQ-041 In PAID: Quarter -> Change=25 strobe and Paid stays 1; then CarPassed -> Paid=0, COLLECT.
REQ-042 Credit 30 with Reset asserted while Quarter is held high -> all outputs 0, no strobe, no event after Reset release; Quarter held for 5 cycles afterward still counts once only.
